// File: rtl/seg7_scan_driver.sv
// Time-multiplexed DIGITS-wide hex display driver with prescaled scan and tear-free frame update.
// Optional: define SEG7_LEADING_ZERO_BLANK_EN to darken leading-zero digits (digit 0 always shown).
module seg7_scan_driver #(
  parameter int unsigned DIGITS          = 4,
  parameter int unsigned SCAN_DIV        = 1000,
  parameter bit          SEG_ACTIVE_HIGH = 1'b1,
  parameter bit          DIG_ACTIVE_HIGH = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [4*DIGITS-1:0]   value,
  input  logic                  load,
  input  logic                  blank,
  output logic [6:0]            lights,
  output logic [DIGITS-1:0]     digit_en,
  output logic                  frame_done
);

  localparam int unsigned VAL_W = 4 * DIGITS;
  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned PRE_W = $clog2(SCAN_DIV);
  localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);
  localparam logic [6:0]        SEG_XOR  = {7{!SEG_ACTIVE_HIGH}};
  localparam logic [DIGITS-1:0] DIG_XOR  = {DIGITS{!DIG_ACTIVE_HIGH}};

  logic [PRE_W-1:0]  presc_q, presc_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [VAL_W-1:0]  pending_q, pending_d;
  logic [VAL_W-1:0]  shown_q, shown_d;
  logic [6:0]        lights_d;
  logic [DIGITS-1:0] digit_en_d;
  logic              frame_done_d;

  logic [3:0]        nib;
  logic [6:0]        seg;
  logic [DIGITS-1:0] onehot;
  logic              dark;

  // Next-state: prescaler, scan index, pending/shown transfer, and registered display outputs
  always_comb begin
    presc_d      = presc_q + PRE_W'(1);
    idx_d        = idx_q;
    pending_d    = pending_q;
    shown_d      = shown_q;
    frame_done_d = 1'b0;
    nib          = 4'h0;
    seg          = 7'b0000000;
    onehot       = '0;
    dark         = 1'b0;

    if (presc_q == PRE_LAST) begin
      presc_d = '0;
      if (idx_q == IDX_LAST) begin
        idx_d        = '0;
        shown_d      = pending_q;   // transfer uses pending from before any same-edge load
        frame_done_d = 1'b1;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end

    if (load) begin
      pending_d = value;
    end

    for (int unsigned k = 0; k < DIGITS; k++) begin
      if (idx_q == IDX_W'(k)) begin
        nib       = shown_q[4*k +: 4];
        onehot[k] = 1'b1;
      end
    end

    case (nib)
      4'h0: seg = 7'b1111110;
      4'h1: seg = 7'b0110000;
      4'h2: seg = 7'b1101101;
      4'h3: seg = 7'b1111001;
      4'h4: seg = 7'b0110011;
      4'h5: seg = 7'b1011011;
      4'h6: seg = 7'b1011111;
      4'h7: seg = 7'b1110000;
      4'h8: seg = 7'b1111111;
      4'h9: seg = 7'b1111011;
      4'hA: seg = 7'b1110111;
      4'hB: seg = 7'b0011111;
      4'hC: seg = 7'b1001110;
      4'hD: seg = 7'b0111101;
      4'hE: seg = 7'b1001111;
      default: seg = 7'b1000111;
    endcase

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    // Digit k>0 is dark when it and every higher nibble of shown are zero
    for (int unsigned k = 1; k < DIGITS; k++) begin
      if ((idx_q == IDX_W'(k)) && ((shown_q >> (4*k)) == '0)) begin
        dark = 1'b1;
      end
    end
`endif

    lights_d   = ((blank || dark) ? 7'b0000000 : seg) ^ SEG_XOR;
    digit_en_d = ((blank || dark) ? '0 : onehot) ^ DIG_XOR;
  end

  // State and output registers; outputs reset to their inactive levels
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_q    <= '0;
      idx_q      <= '0;
      pending_q  <= '0;
      shown_q    <= '0;
      lights     <= SEG_XOR;
      digit_en   <= DIG_XOR;
      frame_done <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      idx_q      <= idx_d;
      pending_q  <= pending_d;
      shown_q    <= shown_d;
      lights     <= lights_d;
      digit_en   <= digit_en_d;
      frame_done <= frame_done_d;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: directed vector table plus randomized run against a frame-level model.
module tb_seg7_scan_driver;

  localparam int D = 4;
  localparam int S = 4;

  logic        clk;
  logic        reset_n;
  logic [15:0] value;
  logic        load;
  logic        blank;
  logic [6:0]  lights, lights_n;
  logic [3:0]  digit_en, dig_n;
  logic        frame_done, fd_n;

  seg7_scan_driver #(.DIGITS(D), .SCAN_DIV(S), .SEG_ACTIVE_HIGH(1'b1), .DIG_ACTIVE_HIGH(1'b1)) u_dut (
    .clk(clk), .reset_n(reset_n), .value(value), .load(load), .blank(blank),
    .lights(lights), .digit_en(digit_en), .frame_done(frame_done)
  );

  seg7_scan_driver #(.DIGITS(D), .SCAN_DIV(S), .SEG_ACTIVE_HIGH(1'b0), .DIG_ACTIVE_HIGH(1'b0)) u_inv (
    .clk(clk), .reset_n(reset_n), .value(value), .load(load), .blank(blank),
    .lights(lights_n), .digit_en(dig_n), .frame_done(fd_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [6:0] seg_tab [16];

  // Frame-level model: cycle count since reset, pending and shown values
  int          cyc;
  logic [15:0] m_pend, m_shown;
  logic [6:0]  m_lights;
  logic [3:0]  m_dig;
  logic        m_fd;

  typedef struct {
    logic        ld;
    logic [15:0] v;
    logic        bl;
    int          n;
    logic        chk;
    logic [3:0]  dig;
    logic [6:0]  seg;
  } vec_t;

  vec_t tab[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    cyc     = 0;
    m_pend  = 16'h0;
    m_shown = 16'h0;
  endtask

  // Apply one cycle of inputs, predict, clock, and compare both instances
  task automatic step(input logic [15:0] v, input logic ld, input logic bl);
    int  idx;
    logic wrap, off;
    value = v;
    load  = ld;
    blank = bl;
    idx  = (cyc / S) % D;
    wrap = ((cyc + 1) % (D * S)) == 0;
    off  = bl;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    if (idx > 0 && (m_shown >> (4 * idx)) == 16'h0) off = 1'b1;
`endif
    m_lights = off ? 7'h00 : seg_tab[(m_shown >> (4 * idx)) & 16'hF];
    m_dig    = off ? 4'h0 : 4'(1 << idx);
    m_fd     = wrap;
    if (wrap) m_shown = m_pend;
    if (ld) m_pend = v;
    cyc++;
    @(posedge clk);
    #1;
    check("lights", 32'(lights), 32'(m_lights));
    check("digit_en", 32'(digit_en), 32'(m_dig));
    check("frame_done", 32'(frame_done), 32'(m_fd));
    check("inverted", 32'({lights_n, dig_n, fd_n}), 32'({~m_lights, ~m_dig, m_fd}));
  endtask

  task automatic check_reset_outputs();
    check("rst_lights", 32'(lights), 32'h0);
    check("rst_digit_en", 32'(digit_en), 32'h0);
    check("rst_frame_done", 32'(frame_done), 32'h0);
    check("rst_inverted", 32'({lights_n, dig_n, fd_n}), 32'({7'h7F, 4'hF, 1'b0}));
  endtask

  initial begin
    seg_tab = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

    // Directed frames from reset: 0000, load 1234, tear-free ABCD, wrap-edge 0F0F, blank, digit 8
    tab.push_back(vec_t'{1'b0, 16'h0000, 1'b0, 4,  1'b1, 4'b0001, 7'b1111110});
    tab.push_back(vec_t'{1'b1, 16'h1234, 1'b0, 1,  1'b1, 4'b0010, 7'b1111110});
    tab.push_back(vec_t'{1'b0, 16'h0000, 1'b0, 3,  1'b1, 4'b0010, 7'b1111110});
    tab.push_back(vec_t'{1'b0, 16'h0000, 1'b0, 4,  1'b1, 4'b0100, 7'b1111110});
    tab.push_back(vec_t'{1'b0, 16'h0000, 1'b0, 4,  1'b1, 4'b1000, 7'b1111110});
    tab.push_back(vec_t'{1'b0, 16'h0000, 1'b0, 4,  1'b1, 4'b0001, 7'b0110011});
    tab.push_back(vec_t'{1'b1, 16'hABCD, 1'b0, 1,  1'b1, 4'b0010, 7'b1111001});
    tab.push_back(vec_t'{1'b0, 16'h0000, 1'b0, 3,  1'b1, 4'b0010, 7'b1111001});
    tab.push_back(vec_t'{1'b0, 16'h0000, 1'b0, 4,  1'b1, 4'b0100, 7'b1101101});
    tab.push_back(vec_t'{1'b0, 16'h0000, 1'b0, 4,  1'b1, 4'b1000, 7'b0110000});
    tab.push_back(vec_t'{1'b0, 16'h0000, 1'b0, 4,  1'b1, 4'b0001, 7'b0111101});
    tab.push_back(vec_t'{1'b0, 16'h0000, 1'b0, 4,  1'b1, 4'b0010, 7'b1001110});
    tab.push_back(vec_t'{1'b0, 16'h0000, 1'b0, 4,  1'b1, 4'b0100, 7'b0011111});
    tab.push_back(vec_t'{1'b0, 16'h0000, 1'b0, 3,  1'b1, 4'b1000, 7'b1110111});
    tab.push_back(vec_t'{1'b1, 16'h0F0F, 1'b0, 1,  1'b1, 4'b1000, 7'b1110111});
    tab.push_back(vec_t'{1'b0, 16'h0000, 1'b0, 4,  1'b1, 4'b0001, 7'b0111101});
    tab.push_back(vec_t'{1'b0, 16'h0000, 1'b0, 4,  1'b1, 4'b0010, 7'b1001110});
    tab.push_back(vec_t'{1'b0, 16'h0000, 1'b0, 4,  1'b1, 4'b0100, 7'b0011111});
    tab.push_back(vec_t'{1'b0, 16'h0000, 1'b0, 4,  1'b1, 4'b1000, 7'b1110111});
    tab.push_back(vec_t'{1'b0, 16'h0000, 1'b0, 4,  1'b1, 4'b0001, 7'b1000111});
    tab.push_back(vec_t'{1'b0, 16'h0000, 1'b0, 4,  1'b1, 4'b0010, 7'b1111110});
    tab.push_back(vec_t'{1'b0, 16'h0000, 1'b0, 4,  1'b1, 4'b0100, 7'b1000111});
    tab.push_back(vec_t'{1'b0, 16'h0000, 1'b0, 4,  1'b1, 4'b1000, 7'b1111110});
    tab.push_back(vec_t'{1'b0, 16'h0000, 1'b0, 4,  1'b1, 4'b0001, 7'b1000111});
    tab.push_back(vec_t'{1'b0, 16'h0000, 1'b0, 4,  1'b1, 4'b0010, 7'b1111110});
    tab.push_back(vec_t'{1'b0, 16'h0000, 1'b1, 10, 1'b1, 4'b0000, 7'b0000000});
    tab.push_back(vec_t'{1'b1, 16'h0008, 1'b0, 1,  1'b1, 4'b0001, 7'b1000111});
    tab.push_back(vec_t'{1'b0, 16'h0000, 1'b0, 1,  1'b1, 4'b0001, 7'b1000111});
    tab.push_back(vec_t'{1'b0, 16'h0000, 1'b0, 12, 1'b0, 4'b0000, 7'b0000000});
    tab.push_back(vec_t'{1'b0, 16'h0000, 1'b0, 4,  1'b1, 4'b0001, 7'b1111111});

    reset_n = 1'b0;
    value   = 16'h0;
    load    = 1'b0;
    blank   = 1'b0;
    model_reset();
    #23;
    check_reset_outputs();
    @(negedge clk);
    reset_n = 1'b1;

    foreach (tab[i]) begin
      for (int j = 0; j < tab[i].n; j++) begin
        step(tab[i].v, tab[i].ld, tab[i].bl);
`ifndef SEG7_LEADING_ZERO_BLANK_EN
        if (tab[i].chk) begin
          check("tab_digit_en", 32'(digit_en), 32'(tab[i].dig));
          check("tab_lights", 32'(lights), 32'(tab[i].seg));
        end
`endif
      end
    end

    for (int i = 0; i < 600; i++) begin
      step(16'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0);
    end

    // Reset mid-scan: outputs go inactive immediately, scan restarts at digit 0
    for (int i = 0; i < 7; i++) step(16'($urandom), 1'b1, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_outputs();
    #20;
    check_reset_outputs();
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      step(16'h0, 1'b0, 1'b0);
      check("post_rst_digit_en", 32'(digit_en), 32'h1);
    end
    for (int i = 0; i < 200; i++) begin
      step(16'($urandom), $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
